// File: rtl/axi_w_id_router_if.sv
// Bundle of the AW-ID push port, the per-slave-port W channels and the routed master-side W channel.
// The router connects through the slave modport; the driving environment uses master.
interface axi_w_id_router_if #(
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6,
    parameter int N_TARG_PORT = 7,
    parameter int FIFO_DEPTH  = 8,
    parameter int LOG_N_TARG  = $clog2(N_TARG_PORT)
);
    localparam int ID_W   = LOG_N_TARG + N_TARG_PORT;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int STRB_W = AXI_DATA_W / 8;

    logic                                    push_ID_i;
    logic [ID_W-1:0]                         ID_i;
    logic                                    grant_FIFO_ID_o;
    logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]  wdata_i;
    logic [N_TARG_PORT-1:0][STRB_W-1:0]      wstrb_i;
    logic [N_TARG_PORT-1:0]                  wlast_i;
    logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]  wuser_i;
    logic [N_TARG_PORT-1:0]                  wvalid_i;
    logic [N_TARG_PORT-1:0]                  wready_o;
    logic [AXI_DATA_W-1:0]                   wdata_o;
    logic [STRB_W-1:0]                       wstrb_o;
    logic                                    wlast_o;
    logic [AXI_USER_W-1:0]                   wuser_o;
    logic                                    wvalid_o;
    logic                                    wready_i;
    logic [CNT_W-1:0]                        fifo_usage_o;

    modport slave (
        input  push_ID_i, ID_i, wdata_i, wstrb_i, wlast_i, wuser_i, wvalid_i, wready_i,
        output grant_FIFO_ID_o, wready_o, wdata_o, wstrb_o, wlast_o, wuser_o, wvalid_o, fifo_usage_o
    );

    modport master (
        output push_ID_i, ID_i, wdata_i, wstrb_i, wlast_i, wuser_i, wvalid_i, wready_i,
        input  grant_FIFO_ID_o, wready_o, wdata_o, wstrb_o, wlast_o, wuser_o, wvalid_o, fifo_usage_o
    );
endinterface

// File: rtl/axi_w_id_router.sv
// W-channel router: queues target-port IDs granted on AW and steers W beats from the head port,
// one complete burst at a time, popping the head when its wlast beat transfers.
module axi_w_id_router #(
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6,
    parameter int N_TARG_PORT = 7,
    parameter int FIFO_DEPTH  = 8,
    parameter int LOG_N_TARG  = $clog2(N_TARG_PORT)
) (
    input logic               clk,
    input logic               rst,
    axi_w_id_router_if.slave  bus
);
    localparam int ID_W   = LOG_N_TARG + N_TARG_PORT;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = AXI_DATA_W / 8;

    logic [ID_W-1:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   grant;
    logic                   notEmpty;
    logic                   pushAcc;
    logic                   pop;
    logic [N_TARG_PORT-1:0] headMask;
    logic [LOG_N_TARG-1:0]  headIdx;
    logic                   routedValid;
    logic                   routedLast;
    logic [AXI_DATA_W-1:0]  routedData;
    logic [STRB_W-1:0]      routedStrb;
    logic [AXI_USER_W-1:0]  routedUser;
    logic [N_TARG_PORT-1:0] portReady;

    assign grant    = (count_q != CNT_W'(FIFO_DEPTH));
    assign notEmpty = (count_q != '0);
    assign pushAcc  = bus.push_ID_i & grant;
    assign headMask = mem_q[rptr_q][N_TARG_PORT-1:0];
    assign headIdx  = mem_q[rptr_q][ID_W-1:N_TARG_PORT];

    // Head decode; everything is forced to zero while empty so stale storage never leaks out.
    always_comb begin
        routedValid = 1'b0;
        routedLast  = 1'b0;
        routedData  = '0;
        routedStrb  = '0;
        routedUser  = '0;
        portReady   = '0;
        if (notEmpty) begin
            routedValid = |(bus.wvalid_i & headMask);
            portReady   = headMask & {N_TARG_PORT{bus.wready_i}};
            for (int i = 0; i < N_TARG_PORT; i++) begin
                if (headIdx == LOG_N_TARG'(i)) begin
                    routedLast = bus.wlast_i[i];
                    routedData = bus.wdata_i[i];
                    routedStrb = bus.wstrb_i[i];
                    routedUser = bus.wuser_i[i];
                end
            end
        end
    end

    assign pop = routedValid & bus.wready_i & routedLast;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (pushAcc) wptr_d = wptr_q + PTR_W'(1);
        if (pop)     rptr_d = rptr_q + PTR_W'(1);
        case ({pushAcc, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only meaningful while count covers it.
    always_ff @(posedge clk) begin
        if (!rst && pushAcc) mem_q[wptr_q] <= bus.ID_i;
    end

    assign bus.grant_FIFO_ID_o = grant;
    assign bus.fifo_usage_o    = count_q;
    assign bus.wvalid_o        = routedValid;
    assign bus.wready_o        = portReady;
    assign bus.wlast_o         = routedLast;
    assign bus.wdata_o         = routedData;
    assign bus.wstrb_o         = routedStrb;
    assign bus.wuser_o         = routedUser;

    // A push while full is silently dropped by the datapath, so it is reported here.
    assert property (@(posedge clk) disable iff (rst) bus.push_ID_i |-> grant)
        else $warning("push_ID_i asserted while ID FIFO full; ID dropped");

    assert property (@(posedge clk) disable iff (rst)
        bus.push_ID_i |-> (bus.ID_i[N_TARG_PORT-1:0] ==
                           (N_TARG_PORT'(1) << bus.ID_i[ID_W-1:N_TARG_PORT])))
        else $error("ID_i one-hot field disagrees with its binary index");

    assert property (@(posedge clk) disable iff (rst)
        (routedValid && !bus.wready_i) |=> routedValid)
        else $error("wvalid_o dropped before transfer");
endmodule

// File: tb/tb_axi_w_id_router.sv
// Directed bench for axi_w_id_router: routing, bursts with stalls, ordering, full FIFO,
// concurrent push/pop across pointer wrap, and reset in the middle of a burst.
module tb_axi_w_id_router;
    localparam int N_TARG_PORT = 7;
    localparam int AXI_DATA_W  = 64;
    localparam int AXI_USER_W  = 6;
    localparam int FIFO_DEPTH  = 8;
    localparam int LOG_N_TARG  = 3;
    localparam int ID_W        = LOG_N_TARG + N_TARG_PORT;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   passCount  = 0;
    int   q[$];

    always #5 clk = ~clk;

    axi_w_id_router_if #(
        .AXI_DATA_W(AXI_DATA_W), .AXI_USER_W(AXI_USER_W),
        .N_TARG_PORT(N_TARG_PORT), .FIFO_DEPTH(FIFO_DEPTH)
    ) bus ();

    axi_w_id_router #(
        .AXI_DATA_W(AXI_DATA_W), .AXI_USER_W(AXI_USER_W),
        .N_TARG_PORT(N_TARG_PORT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [ID_W-1:0] idOf(input int p);
        return {LOG_N_TARG'(p), N_TARG_PORT'(1) << p};
    endfunction

    task automatic setPush(input int p);
        bus.push_ID_i = 1'b1;
        bus.ID_i      = idOf(p);
    endtask

    // Strobe and user fields are derived from the port number so routing of every field is visible.
    task automatic applyStimulus(input int p, input logic valid, input logic last,
                                 input logic [63:0] data, input logic ready);
        bus.wvalid_i[p] = valid;
        bus.wlast_i[p]  = last;
        bus.wdata_i[p]  = data;
        bus.wstrb_i[p]  = 8'hF0 | 8'(p);
        bus.wuser_i[p]  = 6'(p * 5);
        bus.wready_i    = ready;
    endtask

    task automatic clearW();
        bus.wvalid_i = '0;
        bus.wlast_i  = '0;
        bus.wready_i = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.push_ID_i = 1'b0;
        bus.ID_i      = '0;
        bus.wdata_i   = '0;
        bus.wstrb_i   = '0;
        bus.wuser_i   = '0;
        clearW();
        tick();
        tick();
        rst = 1'b0;
        settle();
        checkOutput("reset wvalid_o", 64'(bus.wvalid_o), 0);
        checkOutput("reset wready_o", 64'(bus.wready_o), 0);
        checkOutput("reset grant", 64'(bus.grant_FIFO_ID_o), 1);
        checkOutput("reset usage", 64'(bus.fifo_usage_o), 0);

        // Single beat; the beat offered alongside its push must wait a cycle.
        setPush(2);
        applyStimulus(2, 1, 1, 64'hA5, 1);
        settle();
        checkOutput("single same-cycle valid", 64'(bus.wvalid_o), 0);
        tick();
        bus.push_ID_i = 1'b0;
        settle();
        checkOutput("single wvalid_o", 64'(bus.wvalid_o), 1);
        checkOutput("single wdata_o", bus.wdata_o, 64'hA5);
        checkOutput("single wready_o", 64'(bus.wready_o), 64'b0000100);
        checkOutput("single wstrb_o", 64'(bus.wstrb_o), 64'hF2);
        checkOutput("single wuser_o", 64'(bus.wuser_o), 10);
        checkOutput("single usage", 64'(bus.fifo_usage_o), 1);
        tick();
        clearW();
        settle();
        checkOutput("single empty after", 64'(bus.fifo_usage_o), 0);
        checkOutput("single valid after", 64'(bus.wvalid_o), 0);

        // Four-beat burst on port 4 with a two-cycle stall before beat 3.
        setPush(4);
        tick();
        bus.push_ID_i = 1'b0;
        applyStimulus(4, 1, 0, 64'hB0, 1);
        settle();
        checkOutput("burst b0 data", bus.wdata_o, 64'hB0);
        checkOutput("burst b0 usage", 64'(bus.fifo_usage_o), 1);
        tick();
        applyStimulus(4, 1, 0, 64'hB1, 1);
        settle();
        checkOutput("burst b1 data", bus.wdata_o, 64'hB1);
        tick();
        applyStimulus(4, 1, 0, 64'hB2, 0);
        settle();
        checkOutput("burst stall wready_o", 64'(bus.wready_o), 0);
        checkOutput("burst stall wvalid_o", 64'(bus.wvalid_o), 1);
        checkOutput("burst stall data", bus.wdata_o, 64'hB2);
        tick();
        checkOutput("burst stall2 data", bus.wdata_o, 64'hB2);
        checkOutput("burst stall2 usage", 64'(bus.fifo_usage_o), 1);
        tick();
        bus.wready_i = 1'b1;
        settle();
        checkOutput("burst resume wready_o", 64'(bus.wready_o), 64'b0010000);
        tick();
        applyStimulus(4, 1, 1, 64'hB3, 1);
        settle();
        checkOutput("burst b3 wlast_o", 64'(bus.wlast_o), 1);
        checkOutput("burst b3 usage", 64'(bus.fifo_usage_o), 1);
        tick();
        clearW();
        settle();
        checkOutput("burst done usage", 64'(bus.fifo_usage_o), 0);

        // Ordering: port 0 offers early but must wait for port 5's burst.
        setPush(5);
        tick();
        setPush(0);
        tick();
        bus.push_ID_i = 1'b0;
        applyStimulus(0, 1, 1, 64'hC0, 1);
        settle();
        checkOutput("order early valid", 64'(bus.wvalid_o), 0);
        checkOutput("order early wready_o", 64'(bus.wready_o), 64'b0100000);
        tick();
        checkOutput("order usage", 64'(bus.fifo_usage_o), 2);
        applyStimulus(5, 1, 0, 64'h50, 1);
        settle();
        checkOutput("order p5 b0 data", bus.wdata_o, 64'h50);
        checkOutput("order p5 b0 wready_o", 64'(bus.wready_o), 64'b0100000);
        tick();
        applyStimulus(5, 1, 1, 64'h51, 1);
        settle();
        checkOutput("order p5 b1 wready_o", 64'(bus.wready_o), 64'b0100000);
        tick();
        bus.wvalid_i[5] = 1'b0;
        settle();
        checkOutput("order p0 valid", 64'(bus.wvalid_o), 1);
        checkOutput("order p0 data", bus.wdata_o, 64'hC0);
        checkOutput("order p0 wready_o", 64'(bus.wready_o), 64'b0000001);
        checkOutput("order p0 usage", 64'(bus.fifo_usage_o), 1);
        tick();
        clearW();
        settle();
        checkOutput("order done usage", 64'(bus.fifo_usage_o), 0);

        // Fill to capacity, attempt a ninth push, then drain in order.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            setPush(i % N_TARG_PORT);
            tick();
        end
        bus.push_ID_i = 1'b0;
        settle();
        checkOutput("full usage", 64'(bus.fifo_usage_o), 8);
        checkOutput("full grant", 64'(bus.grant_FIFO_ID_o), 0);
        setPush(6);
        settle();
        checkOutput("full ninth grant", 64'(bus.grant_FIFO_ID_o), 0);
        tick();
        bus.push_ID_i = 1'b0;
        settle();
        checkOutput("full ninth usage", 64'(bus.fifo_usage_o), 8);
        applyStimulus(0, 1, 1, 64'hD0, 1);
        settle();
        checkOutput("full head wready_o", 64'(bus.wready_o), 64'b0000001);
        checkOutput("full head data", bus.wdata_o, 64'hD0);
        tick();
        bus.wvalid_i[0] = 1'b0;
        settle();
        checkOutput("full pop usage", 64'(bus.fifo_usage_o), 7);
        checkOutput("full pop grant", 64'(bus.grant_FIFO_ID_o), 1);
        for (int k = 1; k < FIFO_DEPTH; k++) begin
            clearW();
            applyStimulus(k % N_TARG_PORT, 1, 1, 64'(64'hD0 + k), 1);
            settle();
            checkOutput("full drain wready_o", 64'(bus.wready_o), 64'(N_TARG_PORT'(1) << (k % N_TARG_PORT)));
            tick();
        end
        clearW();
        settle();
        checkOutput("full drained usage", 64'(bus.fifo_usage_o), 0);

        // Hold occupancy at three while every cycle pushes one ID and retires one burst.
        for (int p = 1; p <= 3; p++) begin
            setPush(p);
            q.push_back(p);
            tick();
        end
        bus.push_ID_i = 1'b0;
        for (int j = 0; j < 20; j++) begin
            int newPort;
            int head;
            clearW();
            newPort = (j * 3 + 4) % N_TARG_PORT;
            head    = q[0];
            setPush(newPort);
            applyStimulus(head, 1, 1, 64'(64'h200 + j), 1);
            settle();
            checkOutput("pushpop wready_o", 64'(bus.wready_o), 64'(N_TARG_PORT'(1) << head));
            checkOutput("pushpop data", bus.wdata_o, 64'(64'h200 + j));
            tick();
            bus.push_ID_i = 1'b0;
            q.push_back(newPort);
            void'(q.pop_front());
            checkOutput("pushpop usage", 64'(bus.fifo_usage_o), 3);
        end
        for (int k = 0; k < 3; k++) begin
            int head;
            clearW();
            head = q.pop_front();
            applyStimulus(head, 1, 1, 64'(64'h300 + k), 1);
            settle();
            checkOutput("pushpop drain wready_o", 64'(bus.wready_o), 64'(N_TARG_PORT'(1) << head));
            tick();
        end
        clearW();
        settle();
        checkOutput("pushpop drained usage", 64'(bus.fifo_usage_o), 0);

        // Reset after two of four beats, then confirm a fresh push routes normally.
        setPush(3);
        tick();
        bus.push_ID_i = 1'b0;
        applyStimulus(3, 1, 0, 64'hE0, 1);
        tick();
        applyStimulus(3, 1, 0, 64'hE1, 1);
        tick();
        applyStimulus(3, 1, 0, 64'hE2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        checkOutput("midreset wvalid_o", 64'(bus.wvalid_o), 0);
        checkOutput("midreset wready_o", 64'(bus.wready_o), 0);
        checkOutput("midreset usage", 64'(bus.fifo_usage_o), 0);
        checkOutput("midreset grant", 64'(bus.grant_FIFO_ID_o), 1);
        clearW();
        setPush(6);
        tick();
        bus.push_ID_i = 1'b0;
        applyStimulus(6, 1, 1, 64'h66, 1);
        settle();
        checkOutput("postreset valid", 64'(bus.wvalid_o), 1);
        checkOutput("postreset data", bus.wdata_o, 64'h66);
        checkOutput("postreset wready_o", 64'(bus.wready_o), 64'b1000000);
        tick();
        clearW();
        settle();
        checkOutput("postreset usage", 64'(bus.fifo_usage_o), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
